// File: rtl/palette_loader.sv
// palette_loader: writer side of the video palette RAM load port.
// Assembles packed R,G,B bytes from the ioctl download stream into 24-bit
// entries, issues one single-cycle palette write per entry and reports
// load status (busy / pal_valid / pal_error) to the top level.
// Optional build macro: PAL_BLANK_WRITE_EN -- a completed entry is held until
// vblank and the host is stalled through ioctl_wait while it waits.
module palette_loader #(
  parameter int         ENTRIES  = 64,
  parameter logic [7:0] DL_INDEX = 8'h02
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        vblank,
  output logic        ioctl_wait,
  output logic        load_color,
  output logic [23:0] load_color_data,
  output logic [5:0]  load_color_index,
  output logic        busy,
  output logic        pal_valid,
  output logic        pal_error
);

  localparam logic [6:0] LAST = 7'(ENTRIES);

  // HOLD is only reachable when writes are deferred to vblank.
  typedef enum logic [2:0] {IDLE, COLLECT, HOLD, WRITE, DRAIN} state_t;

  state_t      state, state_nxt;
  logic        dl_q;
  logic        rise, fall;
  logic [1:0]  phase, phase_nxt;
  logic [6:0]  entry, entry_nxt, entry_inc;
  logic [7:0]  r_q, r_nxt, g_q, g_nxt;
  logic [23:0] data_q, data_nxt;
  logic [5:0]  index_q, index_nxt;
  logic        valid_q, valid_nxt, error_q, error_nxt;
  logic        ending, ending_nxt;
  logic        done;
  logic [6:0]  done_cnt;
`ifdef PAL_BLANK_WRITE_EN
  logic [23:0] pend, pend_nxt;
`else
  logic        unused_vblank;
  assign unused_vblank = vblank;
`endif

  assign rise      = ioctl_download & ~dl_q;
  assign fall      = ~ioctl_download & dl_q;
  assign entry_inc = entry + 7'd1;

  // Next-state, byte assembly and end-of-download status decisions
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    entry_nxt  = entry;
    r_nxt      = r_q;
    g_nxt      = g_q;
    data_nxt   = data_q;
    index_nxt  = index_q;
    valid_nxt  = valid_q;
    error_nxt  = error_q;
    ending_nxt = ending;
    done       = 1'b0;
    done_cnt   = entry;
`ifdef PAL_BLANK_WRITE_EN
    pend_nxt   = pend;
`endif
    case (state)
      IDLE: begin
        if (rise && ioctl_index == DL_INDEX) begin
          state_nxt  = COLLECT;
          phase_nxt  = 2'd0;
          entry_nxt  = 7'd0;
          valid_nxt  = 1'b0;
          error_nxt  = 1'b0;
          ending_nxt = 1'b0;
        end
      end
      COLLECT: begin
        if (fall) begin
          done = 1'b1;
        end else if (ioctl_wr) begin
          // Address 0 always starts a fresh file, whatever the current phase.
          if (ioctl_addr == 25'd0) begin
            entry_nxt = 7'd0;
            r_nxt     = ioctl_dout;
            phase_nxt = 2'd1;
          end else begin
            case (phase)
              2'd0: begin
                r_nxt     = ioctl_dout;
                phase_nxt = 2'd1;
              end
              2'd1: begin
                g_nxt     = ioctl_dout;
                phase_nxt = 2'd2;
              end
              default: begin
                phase_nxt = 2'd0;
`ifdef PAL_BLANK_WRITE_EN
                pend_nxt  = {r_q, g_q, ioctl_dout};
                state_nxt = HOLD;
`else
                data_nxt  = {r_q, g_q, ioctl_dout};
                index_nxt = entry[5:0];
                state_nxt = WRITE;
`endif
              end
            endcase
          end
        end
      end
      HOLD: begin
`ifdef PAL_BLANK_WRITE_EN
        // The pending write must still complete if the download ends now.
        if (fall) ending_nxt = 1'b1;
        if (vblank) begin
          data_nxt  = pend;
          index_nxt = entry[5:0];
          state_nxt = WRITE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      WRITE: begin
        entry_nxt = entry_inc;
        if (fall || ending) begin
          done     = 1'b1;
          done_cnt = entry_inc;
        end else begin
          state_nxt = (entry_inc == LAST) ? DRAIN : COLLECT;
          // Phase is 0 here; a byte arriving alongside the write is the next R.
          if (ioctl_wr) begin
            r_nxt     = ioctl_dout;
            phase_nxt = 2'd1;
          end
        end
      end
      DRAIN: begin
        if (fall) done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // A partial entry is dropped; only the completed entry count decides status.
    if (done) begin
      state_nxt  = IDLE;
      phase_nxt  = 2'd0;
      ending_nxt = 1'b0;
      valid_nxt  = (done_cnt == LAST);
      error_nxt  = (done_cnt != LAST);
    end
  end

  // State register and download-edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      dl_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      dl_q  <= ioctl_download;
    end
  end

  // Byte registers, counters, write output registers and sticky status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase   <= 2'd0;
      entry   <= 7'd0;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      data_q  <= 24'd0;
      index_q <= 6'd0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      ending  <= 1'b0;
`ifdef PAL_BLANK_WRITE_EN
      pend    <= 24'd0;
`endif
    end else begin
      phase   <= phase_nxt;
      entry   <= entry_nxt;
      r_q     <= r_nxt;
      g_q     <= g_nxt;
      data_q  <= data_nxt;
      index_q <= index_nxt;
      valid_q <= valid_nxt;
      error_q <= error_nxt;
      ending  <= ending_nxt;
`ifdef PAL_BLANK_WRITE_EN
      pend    <= pend_nxt;
`endif
    end
  end

  assign load_color       = (state == WRITE);
  assign load_color_data  = data_q;
  assign load_color_index = index_q;
  assign busy             = (state != IDLE);
  assign pal_valid        = valid_q;
  assign pal_error        = error_q;
`ifdef PAL_BLANK_WRITE_EN
  assign ioctl_wait       = (state == HOLD);
`else
  assign ioctl_wait       = 1'b0;
`endif

endmodule

// File: tb/tb_palette_loader.sv
// tb_palette_loader: directed bench for palette_loader.
module tb_palette_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        vblank;
  logic        ioctl_wait;
  logic        load_color;
  logic [23:0] load_color_data;
  logic [5:0]  load_color_index;
  logic        busy;
  logic        pal_valid;
  logic        pal_error;

  int checks = 0;
  int errors = 0;
  int lc_total = 0;
  logic [5:0]  log_idx  [0:1023];
  logic [23:0] log_data [0:1023];

  always #5 clk = ~clk;

  palette_loader dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ioctl_download   (ioctl_download),
    .ioctl_index      (ioctl_index),
    .ioctl_wr         (ioctl_wr),
    .ioctl_addr       (ioctl_addr),
    .ioctl_dout       (ioctl_dout),
    .vblank           (vblank),
    .ioctl_wait       (ioctl_wait),
    .load_color       (load_color),
    .load_color_data  (load_color_data),
    .load_color_index (load_color_index),
    .busy             (busy),
    .pal_valid        (pal_valid),
    .pal_error        (pal_error)
  );

  // Log every palette write, sampled on the falling edge
  always @(negedge clk) begin
    if (load_color && lc_total < 1024) begin
      log_idx[lc_total]  = load_color_index;
      log_data[lc_total] = load_color_data;
      lc_total = lc_total + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Palette file contents: entry 0 grey 66, entry 63 black, bytes past 192 are
  // emphasis-variant data that must never reach the RAM.
  function automatic logic [7:0] file_byte(input int i);
    int e;
    e = i / 3;
    if (i >= 192) return 8'((i * 7) ^ 8'h5A);
    if (e == 0)   return 8'h66;
    if (e == 63)  return 8'h00;
    return 8'(e * 37 + (i % 3) * 11 + 3);
  endfunction

  function automatic logic [23:0] exp_entry(input int e);
    return {file_byte(3 * e), file_byte(3 * e + 1), file_byte(3 * e + 2)};
  endfunction

  task automatic start_dl(input logic [7:0] idx);
    @(posedge clk); #1;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
  endtask

  task automatic end_dl();
    repeat (3) @(posedge clk);
    #1 ioctl_download = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Back-to-back byte strobes from address 0, honouring ioctl_wait
  task automatic send_bytes(input int n);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      if (ioctl_wait) begin
        ioctl_wr = 1'b0;
      end else begin
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(i);
        ioctl_dout = file_byte(i);
        i++;
      end
    end
    @(posedge clk); #1 ioctl_wr = 1'b0;
    if (i < n) check("send_timeout", i, n);
  endtask

  task automatic check_run(input string tag, input int base, input int n);
    int bad_idx;
    int bad_dat;
    bad_idx = 0;
    bad_dat = 0;
    check({tag, "_count"}, lc_total - base, n);
    for (int k = 0; k < n && base + k < lc_total; k++) begin
      if (log_idx[base + k] !== k[5:0]) bad_idx++;
      if (log_data[base + k] !== exp_entry(k)) bad_dat++;
    end
    check({tag, "_order_errs"}, bad_idx, 0);
    check({tag, "_data_errs"}, bad_dat, 0);
  endtask

  initial begin
    int base;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'h00;
`ifdef PAL_BLANK_WRITE_EN
    vblank         = 1'b1;
`else
    vblank         = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_load_color", load_color, 0);
    check("rst_data", load_color_data, 0);
    check("rst_index", load_color_index, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", pal_valid, 0);
    check("rst_error", pal_error, 0);
    check("rst_wait", ioctl_wait, 0);
    reset_n = 1'b1;

    // Full 192-byte palette
    base = lc_total;
    start_dl(8'h02);
    repeat (2) @(posedge clk);
    #1 check("full_busy", busy, 1);
    send_bytes(192);
    end_dl();
    check_run("full", base, 64);
    check("full_entry0", log_data[base], 24'h666666);
    check("full_entry63", log_data[base + 63], 24'h000000);
    check("full_valid", pal_valid, 1);
    check("full_error", pal_error, 0);
    check("full_busy_end", busy, 0);

    // Short 100-byte file: 33 entries, trailing byte dropped
    base = lc_total;
    start_dl(8'h02);
    send_bytes(100);
    end_dl();
    check_run("short", base, 33);
    check("short_valid", pal_valid, 0);
    check("short_error", pal_error, 1);

    // 1536-byte emphasis file: only the first 64 entries are written
    base = lc_total;
    start_dl(8'h02);
    send_bytes(1536);
    end_dl();
    check_run("long", base, 64);
    check("long_entry63", log_data[base + 63], 24'h000000);
    check("long_valid", pal_valid, 1);
    check("long_error", pal_error, 0);

    // Foreign download index: ignored entirely, flags untouched
    base = lc_total;
    start_dl(8'h01);
    repeat (2) @(posedge clk);
    #1 check("other_busy", busy, 0);
    send_bytes(192);
    end_dl();
    check("other_writes", lc_total - base, 0);
    check("other_valid", pal_valid, 1);
    check("other_error", pal_error, 0);

    // Address 0 mid-file restarts entry numbering
    start_dl(8'h02);
    send_bytes(10);
    base = lc_total;
    send_bytes(192);
    end_dl();
    check_run("restart", base, 64);
    check("restart_valid", pal_valid, 1);

    // Reset in the middle of a write cycle, then a clean reload
    start_dl(8'h02);
    send_bytes(51);
`ifdef PAL_BLANK_WRITE_EN
    @(posedge clk); #1;
`endif
    check("mid_write_active", load_color, 1);
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check("mid_rst_load_color", load_color, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data", load_color_data, 0);
    check("mid_rst_valid", pal_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    base = lc_total;
    start_dl(8'h02);
    send_bytes(192);
    end_dl();
    check_run("reload", base, 64);
    check("reload_valid", pal_valid, 1);
    check("reload_error", pal_error, 0);

`ifdef PAL_BLANK_WRITE_EN
    // Deferred write: stall until vblank, then exactly one write at index 0
    vblank = 1'b0;
    base = lc_total;
    start_dl(8'h02);
    send_bytes(3);
    repeat (3) @(posedge clk);
    #1;
    check("blank_wait_hi", ioctl_wait, 1);
    check("blank_no_write", lc_total - base, 0);
    vblank = 1'b1;
    @(posedge clk); #1;
    check("blank_load_color", load_color, 1);
    check("blank_index", load_color_index, 0);
    check("blank_data", load_color_data, exp_entry(0));
    check("blank_wait_lo", ioctl_wait, 0);
    end_dl();
    check("blank_writes", lc_total - base, 1);
    check("blank_error", pal_error, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
